// File: rtl/fifo_rx_pkg.sv
// fifo_rx_pkg: register map, bit positions and CTRL layout shared by the receive FIFO slice
package fifo_rx_pkg;

    localparam int ADDR_DATA   = 'h0;
    localparam int ADDR_STATUS = 'h4;
    localparam int ADDR_CTRL   = 'h8;
    localparam int ADDR_CMD    = 'hC;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_MSB    = 1;
    localparam int CTRL_THR_LO = 8;

    localparam int ST_EMPTY  = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_LVL_LO = 8;

    localparam int CMD_CLR_OVF = 0;
    localparam int CMD_FLUSH   = 1;

    typedef struct packed {
        logic [7:0] irq_thresh;
        logic       msb_first;
        logic       enable;
    } ctrl_t;

    function automatic ctrl_t ctrl_unpack(logic [31:0] w);
        ctrl_t c;
        c.irq_thresh = w[CTRL_THR_LO +: 8];
        c.msb_first  = w[CTRL_MSB];
        c.enable     = w[CTRL_EN];
        return c;
    endfunction

    function automatic logic [31:0] ctrl_pack(ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_THR_LO +: 8] = c.irq_thresh;
        w[CTRL_MSB]         = c.msb_first;
        w[CTRL_EN]          = c.enable;
        return w;
    endfunction

endpackage

// File: rtl/fifo_rx_apb_if.sv
// fifo_rx_apb_if: APB3 slave bus bundle for the receive FIFO
interface fifo_rx_apb_if #(parameter int PADDR_W = 4);

    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [PADDR_W-1:0] paddr;
    logic [31:0]        pwdata;
    logic [31:0]        prdata;
    logic               pready;
    logic               pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/fifo_rx_apb_rx_deser.sv
// rx_deser: collects one bit per CDR strobe into a word and flags the word on its last bit
module rx_deser #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              msb_first_i,
    input  logic              clr_i,
    input  logic              en_cdr_i,
    input  logic              data_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_valid_o
);

    localparam int CNT_W = DATA_W > 1 ? $clog2(DATA_W) : 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d, shifted;
    logic              take, last;

    // Shift in the new bit; the completed word is presented combinationally so it is pushed on the same edge
    always_comb begin
        shifted      = msb_first_i ? (sr_q << 1) | DATA_W'(data_i)
                                   : (sr_q >> 1) | (DATA_W'(data_i) << (DATA_W - 1));
        take         = enable_i & en_cdr_i & ~clr_i;
        last         = cnt_q == CNT_W'(DATA_W - 1);
        word_o       = shifted;
        word_valid_o = take & last;
        sr_d         = take ? shifted : sr_q;
        cnt_d        = (~enable_i | clr_i | (take & last)) ? '0 : cnt_q + CNT_W'(take);
    end

    // Bit counter and shift register; a cleared counter discards any partial word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/fifo_rx_apb.sv
// fifo_rx_apb: CDR bit stream to word FIFO, read by the CPU through a zero-wait APB slave
module fifo_rx_apb
    import fifo_rx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int PADDR_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en_cdr,
    input  logic           data_in,
    fifo_rx_apb_if.slave   apb,
    output logic           irq
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d, level;
    ctrl_t             ctrl_q, ctrl_d;
    logic              ovf_q, ovf_d, irq_q, irq_d, pslverr_q, pslverr_d;
    logic [31:0]       prdata_q, prdata_d, status, rdata;
    logic [7:0]        lvl8;
    logic              empty, full, setup, access, ok, err;
    logic              is_data, is_status, is_ctrl, is_cmd;
    logic              pop, push, push_req, drop, flush, clr_ovf, ctrl_we, cmd_we, msb_chg;
    logic              word_valid;
    logic [DATA_W-1:0] word;
    logic              unused_pwdata;

    rx_deser #(.DATA_W(DATA_W)) u_deser (
        .clk          (clk),
        .reset        (reset),
        .enable_i     (ctrl_q.enable),
        .msb_first_i  (ctrl_q.msb_first),
        .clr_i        (flush | msb_chg),
        .en_cdr_i     (en_cdr),
        .data_i       (data_in),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    // Decode, error detection and FIFO next-state; errors are decided at setup and gate the access-phase action
    always_comb begin
        level     = wptr_q - rptr_q;
        lvl8      = 8'(level);
        empty     = level == '0;
        full      = level[AW];
        status    = '0;
        status[ST_EMPTY]       = empty;
        status[ST_FULL]        = full;
        status[ST_OVF]         = ovf_q;
        status[ST_LVL_LO +: 8] = lvl8;
        setup     = apb.psel & ~apb.penable;
        access    = apb.psel & apb.penable;
        is_data   = apb.paddr == PADDR_W'(ADDR_DATA);
        is_status = apb.paddr == PADDR_W'(ADDR_STATUS);
        is_ctrl   = apb.paddr == PADDR_W'(ADDR_CTRL);
        is_cmd    = apb.paddr == PADDR_W'(ADDR_CMD);
        err       = ~(is_data | is_status | is_ctrl | is_cmd)
                  | (apb.pwrite & (is_data | is_status))
                  | (~apb.pwrite & is_cmd)
                  | (~apb.pwrite & is_data & empty);
        rdata     = is_data   ? 32'(mem[rptr_q[AW-1:0]]) :
                    is_status ? status :
                    is_ctrl   ? ctrl_pack(ctrl_q) : '0;
        prdata_d  = (setup & ~apb.pwrite & ~err) ? rdata : '0;
        pslverr_d = setup & err;
        ok        = access & ~pslverr_q;
        pop       = ok & ~apb.pwrite & is_data;
        ctrl_we   = ok & apb.pwrite & is_ctrl;
        cmd_we    = ok & apb.pwrite & is_cmd;
        flush     = cmd_we & apb.pwdata[CMD_FLUSH];
        clr_ovf   = cmd_we & apb.pwdata[CMD_CLR_OVF];
        ctrl_d    = ctrl_we ? ctrl_unpack(apb.pwdata) : ctrl_q;
        msb_chg   = ctrl_we & (ctrl_d.msb_first != ctrl_q.msb_first);
        push_req  = word_valid & ~flush;
        push      = push_req & (~full | pop);
        drop      = push_req & full & ~pop;
        wptr_d    = flush ? '0 : wptr_q + (AW+1)'(push);
        rptr_d    = flush ? '0 : rptr_q + (AW+1)'(pop);
        ovf_d     = drop | (ovf_q & ~clr_ovf);
        irq_d     = ((ctrl_q.irq_thresh != 8'd0) && (lvl8 >= ctrl_q.irq_thresh)) || ovf_q;
    end

    // Control/status state, pointers and the registered APB response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            ctrl_q    <= '0;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ctrl_q    <= ctrl_d;
            ovf_q     <= ovf_d;
            irq_q     <= irq_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Word storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q[AW-1:0]] <= word;
    end

    assign apb.prdata  = prdata_q;
    assign apb.pslverr = pslverr_q;
    assign apb.pready  = 1'b1;
    assign irq         = irq_q;
    assign unused_pwdata = ^apb.pwdata;

endmodule

// File: tb/tb_fifo_rx_apb.sv
// tb_fifo_rx_apb: directed stimulus with a scoreboard queue checked by an APB access-phase monitor
module tb_fifo_rx_apb;

    localparam logic [4:0] A_DATA = 5'h0, A_STATUS = 5'h4, A_CTRL = 5'h8, A_CMD = 5'hC;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en_cdr = 1'b0;
    logic data_in = 1'b0;
    logic irq;
    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    fifo_rx_apb_if #(.PADDR_W(5)) apb();

    fifo_rx_apb #(.DATA_W(8), .DEPTH(16), .PADDR_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .en_cdr  (en_cdr),
        .data_in (data_in),
        .apb     (apb),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (apb.psel && apb.penable) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_access: got access to 0x%0h expected none", apb.paddr);
            end else begin
                mon_e = q.pop_front();
                check({mon_e.name, "_prdata"}, apb.prdata, mon_e.data);
                check({mon_e.name, "_pslverr"}, 32'(apb.pslverr), 32'(mon_e.err));
            end
        end
    end

    task automatic xfer(input string name, input logic wr, input logic [4:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data, input logic exp_err);
        q.push_back('{name: name, data: exp_data, err: exp_err});
        apb.psel = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite = wr;
        apb.paddr = addr;
        apb.pwdata = wdata;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        @(posedge clk); #1;
        apb.psel = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite = 1'b0;
    endtask

    task automatic rd(input string name, input logic [4:0] addr, input logic [31:0] exp_data, input logic exp_err);
        xfer(name, 1'b0, addr, 32'h0, exp_data, exp_err);
    endtask

    task automatic wr(input string name, input logic [4:0] addr, input logic [31:0] wdata, input logic exp_err);
        xfer(name, 1'b1, addr, wdata, 32'h0, exp_err);
    endtask

    task automatic send_bit(input logic b);
        en_cdr = 1'b1;
        data_in = b;
        @(posedge clk); #1;
        en_cdr = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] w, input int n, input logic msb);
        for (int i = 0; i < n; i++) send_bit(msb ? w[7-i] : w[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        apb.psel = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite = 1'b0;
        apb.paddr = '0;
        apb.pwdata = '0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_prdata", apb.prdata, 32'h0);
        check("rst_pslverr", 32'(apb.pslverr), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_pready", 32'(apb.pready), 32'h1);
        reset = 1'b0;
        @(posedge clk); #1;
        rd("rst_status", A_STATUS, 32'h1, 1'b0);
        // bit ordering
        wr("ctrl_msb", A_CTRL, 32'h3, 1'b0);
        send_bits(8'hA5, 8, 1'b1);
        rd("msb_a5", A_DATA, 32'hA5, 1'b0);
        rd("msb_empty", A_STATUS, 32'h1, 1'b0);
        wr("ctrl_lsb", A_CTRL, 32'h1, 1'b0);
        send_bits(8'hA5, 8, 1'b1);
        rd("lsb_a5", A_DATA, 32'hA5, 1'b0);
        send_bits(8'h80, 8, 1'b1);
        rd("lsb_01", A_DATA, 32'h01, 1'b0);
        // fill and overflow
        for (int i = 0; i < 17; i++) send_bits(8'(i), 8, 1'b0);
        @(posedge clk); #1;
        check("ovf_irq", 32'(irq), 32'h1);
        rd("full_status", A_STATUS, 32'h1006, 1'b0);
        for (int i = 0; i < 16; i++) rd($sformatf("drain_%0d", i), A_DATA, 32'(i), 1'b0);
        rd("read_empty", A_DATA, 32'h0, 1'b1);
        rd("ovf_sticky", A_STATUS, 32'h5, 1'b0);
        wr("clr_ovf", A_CMD, 32'h1, 1'b0);
        rd("ovf_cleared", A_STATUS, 32'h1, 1'b0);
        @(posedge clk); #1;
        check("irq_after_clr", 32'(irq), 32'h0);
        // simultaneous push/pop while full, then while empty
        for (int i = 0; i < 16; i++) send_bits(8'(32 + i), 8, 1'b0);
        send_bits(8'h55, 7, 1'b0);
        fork
            rd("full_pushpop", A_DATA, 32'h20, 1'b0);
            begin @(posedge clk); #1; send_bit(1'b0); end
        join
        rd("full_pushpop_status", A_STATUS, 32'h1002, 1'b0);
        wr("flush_full", A_CMD, 32'h2, 1'b0);
        rd("flushed_status", A_STATUS, 32'h1, 1'b0);
        send_bits(8'h3C, 7, 1'b0);
        fork
            rd("empty_pushpop", A_DATA, 32'h0, 1'b1);
            begin @(posedge clk); #1; send_bit(1'b0); end
        join
        rd("empty_pushpop_status", A_STATUS, 32'h0100, 1'b0);
        rd("empty_pushpop_word", A_DATA, 32'h3C, 1'b0);
        // threshold interrupt
        wr("ctrl_thresh", A_CTRL, 32'h0401, 1'b0);
        for (int i = 1; i <= 3; i++) send_bits(8'(i), 8, 1'b0);
        @(posedge clk); #1;
        check("irq_level3", 32'(irq), 32'h0);
        send_bits(8'h04, 8, 1'b0);
        check("irq_lag", 32'(irq), 32'h0);
        @(posedge clk); #1;
        check("irq_level4", 32'(irq), 32'h1);
        rd("thresh_pop", A_DATA, 32'h1, 1'b0);
        @(posedge clk); #1;
        check("irq_after_pop", 32'(irq), 32'h0);
        // CMD flush of a partial word and error accesses
        send_bits(8'h07, 3, 1'b0);
        wr("flush_partial", A_CMD, 32'h2, 1'b0);
        rd("flush_status", A_STATUS, 32'h1, 1'b0);
        send_bits(8'h81, 8, 1'b0);
        rd("align_after_flush", A_DATA, 32'h81, 1'b0);
        wr("wr_status", A_STATUS, 32'hFFFF, 1'b1);
        rd("status_unchanged", A_STATUS, 32'h1, 1'b0);
        rd("rd_unmapped", 5'h10, 32'h0, 1'b1);
        rd("rd_cmd", A_CMD, 32'h0, 1'b1);
        wr("wr_data", A_DATA, 32'h12, 1'b1);
        wr("wr_unmapped", 5'h14, 32'h3, 1'b1);
        rd("ctrl_unchanged", A_CTRL, 32'h0401, 1'b0);
        rd("status_final", A_STATUS, 32'h1, 1'b0);
        // asynchronous reset in the middle of an access phase
        for (int i = 0; i < 5; i++) send_bits(8'(8'h11 + i), 8, 1'b0);
        @(posedge clk); #1;
        check("pre_rst_irq", 32'(irq), 32'h1);
        apb.psel = 1'b1;
        apb.pwrite = 1'b0;
        apb.paddr = A_STATUS;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        check("pre_rst_prdata", apb.prdata, 32'h0500);
        #2 reset = 1'b1;
        #1;
        check("async_rst_prdata", apb.prdata, 32'h0);
        check("async_rst_pslverr", 32'(apb.pslverr), 32'h0);
        check("async_rst_irq", 32'(irq), 32'h0);
        apb.psel = 1'b0;
        apb.penable = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        rd("post_rst_status", A_STATUS, 32'h1, 1'b0);
        rd("post_rst_ctrl", A_CTRL, 32'h0, 1'b0);
        check("post_rst_irq", 32'(irq), 32'h0);
        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rx_apb.md
Name: fifo_rx_apb

Overview:
Parametrised receive path: deserialises a recovered bit stream (one bit per `en_cdr` strobe) into DATA_W-bit words and buffers them in a DEPTH-entry FIFO. The FIFO is read by the CPU over a zero-wait-state APB slave. The slave adds control, status, sticky overflow, flush and a level-threshold interrupt. It sits between the CDR and the APB interconnect of the Zigbee receiver.

Parameters:
- DATA_W, 8: bits per received word, 1..32.
- DEPTH, 16: FIFO entries; power of two, 2..128.
- PADDR_W, 4: APB address width; registers are word-aligned at byte offsets 0x0/0x4/0x8/0xC.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en_cdr  in  1  bit-sample strobe from the CDR; data_in is valid on every cycle this is 1.
- data_in  in  1  recovered serial bit.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  APB write.
- paddr  in  PADDR_W  APB byte address.
- pwdata  in  32  APB write data.
- prdata  out  32  APB read data.
- pready  out  1  APB ready.
- pslverr  out  1  APB error.
- irq  out  1  level/overflow interrupt.

Behaviour:
- Interface (already decided): one clock, `clk`. Reset `reset` is asynchronous and active-high. All state is cleared immediately on assertion; the block leaves reset on the first `clk` edge after deassertion.
- Reset values:
  - `prdata` = 0, `pslverr` = 0, `irq` = 0, `pready` = 1.
  - FIFO empty, bit counter 0, CTRL = 0, overflow = 0.
- Register map:
  - 0x0 DATA (RO): read pops the head word, zero-extended.
  - 0x4 STATUS (RO): [0] empty, [1] full, [2] overflow (sticky), [15:8] level (0..DEPTH).
  - 0x8 CTRL (RW): [0] enable, [1] msb_first, [15:8] irq_thresh.
  - 0xC CMD (WO): [0] clear overflow, [1] flush. Write-1 action, self-clearing; reads return 0.
- APB protocol:
  - `pready` is tied to 1 (no wait states).
  - The access is the cycle with `psel & penable`.
  - `prdata` and `pslverr` are registered, set on the setup-phase edge and valid during the access phase. Outside access they hold 0.
  - Only one pop or register write per transfer, taken on the access-phase edge.
- `pslverr` = 1 for any of:
  - an unmapped address;
  - a write to DATA or STATUS;
  - a read of CMD;
  - a read of DATA while empty (`prdata` = 0, no pop, no state change).
- Deserialiser:
  - When enable = 1, each `en_cdr` cycle shifts `data_in` into the shift register and increments the bit counter 0..DATA_W-1.
  - msb_first = 1: the first bit received lands at bit DATA_W-1. msb_first = 0: the first bit lands at bit 0.
  - On the DATA_W-th bit the word is pushed the same edge and the counter wraps to 0.
  - The word is readable (empty = 0) from the next cycle: 1-cycle latency from the final `en_cdr` sample.
  - enable = 0, or a change of msb_first, clears the counter and discards the partial word; `en_cdr` is then ignored.
- FIFO:
  - Pointers are log2(DEPTH)+1 bits wide, with wrap-around at DEPTH.
  - Push while full, without a simultaneous pop: the word is dropped and overflow is set.
  - Push and pop in the same cycle while full: both succeed and the level is unchanged.
  - Push and pop in the same cycle while empty: the pop errors and the push succeeds (level becomes 1).
- Flush: clears the pointers, the level and the bit counter. It does not clear overflow or CTRL. A push on the same cycle as a flush is discarded.
- Clear overflow and a new overflow on the same cycle: overflow stays 1 (set wins).
- irq is registered and equals (irq_thresh != 0 && level >= irq_thresh) || overflow, so it lags the level change by one cycle.

Decomposition:
- Shared package `fifo_rx_pkg` holds:
  - register offset localparams (ADDR_DATA, ADDR_STATUS, ADDR_CTRL, ADDR_CMD);
  - CTRL/STATUS/CMD bit-index constants;
  - a packed typedef `ctrl_t`.
- One sub-module `rx_deser`: shift register, bit counter and msb_first handling. Its outputs are `word` and a one-cycle `word_valid`.
- The FIFO storage, pointers and APB decode stay in `fifo_rx_apb`.

Test Plan:
1. Reset mid-run: assert `reset` asynchronously between edges. Required: `prdata`, `irq` and `pslverr` go to 0 immediately, and STATUS then reads 0x0000_0001.
2. Bit ordering: enable = 1, msb_first = 1, send 8 strobes with bits 1,0,1,0,0,1,0,1. Required: the DATA read returns 0xA5 and the next STATUS read shows empty. Repeat with msb_first = 0: required read is 0xA5 as well (palindrome-safe check), then pattern 1,0,0,0,0,0,0,0 must read 0x01.
3. Fill and overflow: push 17 words 0x00..0x10 with DEPTH = 16. Required: STATUS = full, level 16, overflow = 1, irq = 1. Reads then return 0x00..0x0F in order; the 17th read gives `pslverr` = 1.
4. Simultaneous events: with the FIFO full, complete a word in the same cycle as a DATA read. Required: level stays 16 and overflow stays 0. With the FIFO empty, do the same. Required: `pslverr` = 1 and level becomes 1.
5. Threshold irq: irq_thresh = 4. Push 3 words: required irq = 0. Push a 4th: required irq = 1 one cycle after the push. One DATA read: required irq = 0.
6. CMD and errors: partial word (3 bits), then CMD flush = 1. Required: level 0 and the next word aligns from bit 0. A write to STATUS, and a read of address 0x10 (requires PADDR_W ≥ 5), each give `pslverr` = 1 with no state change. CMD clear-overflow returns overflow to 0.
